// File: rtl/primitive_sr_bram_multitap.sv
// BRAM-backed circular delay line with one write port and NTAPS programmable read taps.
// Define IKA2151_SR_BRAM_FWD_EN to forward same-tick write data to taps whose delay is 1.
module primitive_sr_bram_multitap #(
  parameter  int WIDTH  = 8,
  parameter  int LENGTH = 32,
  parameter  int NTAPS  = 2,
  localparam int AW     = $clog2(LENGTH),
  localparam int DW     = $clog2(LENGTH + 1)
) (
  input  logic                   i_EMUCLK,
  input  logic                   i_RST,
  input  logic                   i_CEN_n,
  input  logic                   i_CNTRRST,
  input  logic                   i_WR,
  input  logic [WIDTH-1:0]       i_D,
  input  logic [NTAPS*DW-1:0]    i_TAPDLY,
  output logic [NTAPS*WIDTH-1:0] o_Q_TAP,
  output logic [AW-1:0]          o_SLOT,
  output logic                   o_WRAP,
  output logic                   o_BUSY
);

  localparam int SW = AW + 2;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t                   r_state;
  logic [AW-1:0]            r_ptr;
  logic [AW-1:0]            r_clrcnt;
  logic [NTAPS*WIDTH-1:0]   r_q;
  logic                     r_wrap;
  logic                     r_busy;
  logic [WIDTH-1:0]         r_mem [LENGTH];

  logic                     w_tick;
  logic                     w_ptrLast;
  logic                     w_clrLast;
  logic [AW-1:0]            w_ptrNext;
  logic                     w_wen;
  logic [AW-1:0]            w_waddr;
  logic [WIDTH-1:0]         w_wdata;
  logic [NTAPS*WIDTH-1:0]   w_tapNext;

  assign w_tick    = ~i_CEN_n;
  assign w_ptrLast = (r_ptr == AW'(LENGTH - 1));
  assign w_clrLast = (r_clrcnt == AW'(LENGTH - 1));
  assign w_ptrNext = (i_CNTRRST || w_ptrLast) ? '0 : r_ptr + 1'b1;

  // Single write port shared by the clear sequencer and normal slot writes.
  always_comb begin
    w_wen   = 1'b0;
    w_waddr = r_ptr;
    w_wdata = i_D;
    if (w_tick && !i_RST) begin
      if (r_state == ST_CLEAR) begin
        w_wen   = 1'b1;
        w_waddr = r_clrcnt;
        w_wdata = '0;
      end else if (i_WR) begin
        w_wen = 1'b1;
      end
    end
  end

  always_ff @(posedge i_EMUCLK) begin
    if (w_wen) r_mem[w_waddr] <= w_wdata;
  end

  for (genvar k = 0; k < NTAPS; k++) begin : g_tap
    logic [DW-1:0]    w_dlyRaw;
    logic [DW-1:0]    w_dly;
    logic [SW-1:0]    w_sum;
    logic [AW-1:0]    w_raddr;
    logic [WIDTH-1:0] w_rdata;

    assign w_dlyRaw = i_TAPDLY[k*DW +: DW];
    assign w_dly    = (w_dlyRaw == '0 || w_dlyRaw > DW'(LENGTH)) ? DW'(LENGTH) : w_dlyRaw;
    // p + 1 - D kept non-negative by adding LENGTH; the sum lies in 1..2*LENGTH-1.
    assign w_sum    = SW'(r_ptr) + SW'(LENGTH + 1) - SW'(w_dly);
    assign w_raddr  = (w_sum >= SW'(LENGTH)) ? AW'(w_sum - SW'(LENGTH)) : AW'(w_sum);
    assign w_rdata  = r_mem[w_raddr];

`ifdef IKA2151_SR_BRAM_FWD_EN
    assign w_tapNext[k*WIDTH +: WIDTH] = (w_dly == DW'(1) && i_WR) ? i_D : w_rdata;
`else
    assign w_tapNext[k*WIDTH +: WIDTH] = w_rdata;
`endif
  end

  // Clear sequencer runs LENGTH ticks after every reset, then the ring runs freely.
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      r_state  <= ST_CLEAR;
      r_clrcnt <= '0;
      r_ptr    <= '0;
      r_q      <= '0;
      r_wrap   <= 1'b0;
      r_busy   <= 1'b1;
    end else if (w_tick) begin
      case (r_state)
        ST_CLEAR: begin
          r_q      <= '0;
          r_wrap   <= 1'b0;
          r_clrcnt <= r_clrcnt + 1'b1;
          if (w_clrLast) begin
            r_state  <= ST_RUN;
            r_busy   <= 1'b0;
            r_clrcnt <= '0;
          end
        end
        ST_RUN: begin
          r_q    <= w_tapNext;
          r_wrap <= i_CNTRRST || w_ptrLast;
          r_ptr  <= w_ptrNext;
        end
        default: r_state <= ST_CLEAR;
      endcase
    end
  end

  assign o_Q_TAP = r_q;
  assign o_SLOT  = r_ptr;
  assign o_WRAP  = r_wrap;
  assign o_BUSY  = r_busy;

endmodule
